// File: rtl/dsp_wresp_ordered_router.sv
// Write-response dispatcher: returns slave B beats to one master in AW order,
// synthesising DECERR for unmapped AWs, through a single registered output stage.
module dsp_wresp_ordered_router #(
    parameter int unsigned SLV_AMT         = 4,
    parameter int unsigned OUTSTANDING_AMT = 8,
    parameter int unsigned RESP_DEPTH      = 4,
    parameter int unsigned TRANS_MST_ID_W  = 5,
    parameter int unsigned TRANS_WR_RESP_W = 2,
    parameter int unsigned SLV_ID_W        = $clog2(SLV_AMT),
    parameter int unsigned CNT_W           = $clog2(OUTSTANDING_AMT + 1)
) (
    input  logic                                 ACLK_i,
    input  logic                                 ARESET_i,
    input  logic                                 dsp_AW_shift_en_i,
    input  logic [SLV_ID_W-1:0]                  dsp_AW_slv_id_i,
    input  logic                                 dsp_AW_decerr_i,
    input  logic [TRANS_MST_ID_W-1:0]            dsp_AW_mst_id_i,
    output logic                                 dsp_AW_ready_o,
    input  logic [TRANS_MST_ID_W*SLV_AMT-1:0]    sa_BID_i,
    input  logic [TRANS_WR_RESP_W*SLV_AMT-1:0]   sa_BRESP_i,
    input  logic [SLV_AMT-1:0]                   sa_BVALID_i,
    output logic [SLV_AMT-1:0]                   sa_BREADY_o,
    output logic [TRANS_MST_ID_W-1:0]            m_BID_o,
    output logic [TRANS_WR_RESP_W-1:0]           m_BRESP_o,
    output logic                                 m_BVALID_o,
    input  logic                                 m_BREADY_i,
    output logic [CNT_W-1:0]                     outstanding_cnt_o
);

    localparam int unsigned ORD_AW = $clog2(OUTSTANDING_AMT);
    localparam int unsigned RSP_AW = $clog2(RESP_DEPTH);
    localparam int unsigned ORD_EW = 1 + SLV_ID_W + TRANS_MST_ID_W;
    localparam int unsigned RSP_EW = TRANS_MST_ID_W + TRANS_WR_RESP_W;

    // Order FIFO storage and pointers (extra wrap bit distinguishes full from empty)
    logic [ORD_EW-1:0]          r_ord_mem [OUTSTANDING_AMT];
    logic [ORD_AW:0]            r_ord_wptr;
    logic [ORD_AW:0]            r_ord_rptr;
    logic [CNT_W-1:0]           r_cnt;

    logic [RSP_EW-1:0]          r_rsp_mem  [SLV_AMT][RESP_DEPTH];
    logic [RSP_AW:0]            r_rsp_wptr [SLV_AMT];
    logic [RSP_AW:0]            r_rsp_rptr [SLV_AMT];

    logic                       r_bvalid;
    logic [TRANS_MST_ID_W-1:0]  r_bid;
    logic [TRANS_WR_RESP_W-1:0] r_bresp;

    logic                       w_ord_full;
    logic                       w_ord_empty;
    logic                       w_ord_push;
    logic                       w_ord_pop;
    logic [ORD_EW-1:0]          w_head;
    logic                       w_head_decerr;
    logic [SLV_ID_W-1:0]        w_head_slv;
    logic [TRANS_MST_ID_W-1:0]  w_head_id;
    logic [RSP_EW-1:0]          w_head_rsp;
    logic                       w_head_avail;
    logic                       w_load_ok;
    logic                       w_pop_decerr;
    logic                       w_pop_slv;

    logic [SLV_AMT-1:0]         w_rsp_full;
    logic [SLV_AMT-1:0]         w_rsp_empty;
    logic [SLV_AMT-1:0]         w_rsp_push;
    logic [SLV_AMT-1:0]         w_rsp_pop;

    assign w_ord_full  = (r_ord_wptr[ORD_AW] != r_ord_rptr[ORD_AW]) &&
                         (r_ord_wptr[ORD_AW-1:0] == r_ord_rptr[ORD_AW-1:0]);
    assign w_ord_empty = (r_ord_wptr == r_ord_rptr);
    assign w_ord_push  = dsp_AW_shift_en_i && !w_ord_full;

    assign w_head        = r_ord_mem[r_ord_rptr[ORD_AW-1:0]];
    assign w_head_decerr = w_head[ORD_EW-1];
    assign w_head_slv    = w_head[TRANS_MST_ID_W +: SLV_ID_W];
    assign w_head_id     = w_head[TRANS_MST_ID_W-1:0];
    assign w_head_avail  = !w_rsp_empty[w_head_slv];
    assign w_head_rsp    = r_rsp_mem[w_head_slv][r_rsp_rptr[w_head_slv][RSP_AW-1:0]];

    // Only the slave FIFO named by the order head may feed the output register
    assign w_load_ok    = !r_bvalid || m_BREADY_i;
    assign w_pop_decerr = !w_ord_empty && w_head_decerr && w_load_ok;
    assign w_pop_slv    = !w_ord_empty && !w_head_decerr && w_head_avail && w_load_ok;
    assign w_ord_pop    = w_pop_decerr || w_pop_slv;

    always_comb begin
        w_rsp_full  = '0;
        w_rsp_empty = '0;
        for (int s = 0; s < SLV_AMT; s++) begin
            w_rsp_full[s]  = (r_rsp_wptr[s][RSP_AW] != r_rsp_rptr[s][RSP_AW]) &&
                             (r_rsp_wptr[s][RSP_AW-1:0] == r_rsp_rptr[s][RSP_AW-1:0]);
            w_rsp_empty[s] = (r_rsp_wptr[s] == r_rsp_rptr[s]);
        end
    end

    always_comb begin
        w_rsp_push = '0;
        w_rsp_pop  = '0;
        for (int s = 0; s < SLV_AMT; s++) begin
            w_rsp_push[s] = sa_BVALID_i[s] && !w_rsp_full[s];
            w_rsp_pop[s]  = w_pop_slv && (w_head_slv == SLV_ID_W'(s));
        end
    end

    // Storage arrays carry no reset; validity lives entirely in the pointers
    always_ff @(posedge ACLK_i) begin
        if (w_ord_push) begin
            r_ord_mem[r_ord_wptr[ORD_AW-1:0]] <= {dsp_AW_decerr_i, dsp_AW_slv_id_i, dsp_AW_mst_id_i};
        end
        for (int s = 0; s < SLV_AMT; s++) begin
            if (w_rsp_push[s]) begin
                r_rsp_mem[s][r_rsp_wptr[s][RSP_AW-1:0]] <=
                    {sa_BID_i[s*TRANS_MST_ID_W +: TRANS_MST_ID_W],
                     sa_BRESP_i[s*TRANS_WR_RESP_W +: TRANS_WR_RESP_W]};
            end
        end
    end

    always_ff @(posedge ACLK_i or posedge ARESET_i) begin
        if (ARESET_i) begin
            r_ord_wptr <= '0;
            r_ord_rptr <= '0;
            r_cnt      <= '0;
            r_bvalid   <= 1'b0;
            r_bid      <= '0;
            r_bresp    <= '0;
            for (int s = 0; s < SLV_AMT; s++) begin
                r_rsp_wptr[s] <= '0;
                r_rsp_rptr[s] <= '0;
            end
        end else begin
            if (w_ord_push) r_ord_wptr <= r_ord_wptr + (ORD_AW+1)'(1);
            if (w_ord_pop)  r_ord_rptr <= r_ord_rptr + (ORD_AW+1)'(1);

            case ({w_ord_push, w_ord_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: ;
            endcase

            for (int s = 0; s < SLV_AMT; s++) begin
                if (w_rsp_push[s]) r_rsp_wptr[s] <= r_rsp_wptr[s] + (RSP_AW+1)'(1);
                if (w_rsp_pop[s])  r_rsp_rptr[s] <= r_rsp_rptr[s] + (RSP_AW+1)'(1);
            end

            if (w_pop_decerr) begin
                r_bvalid <= 1'b1;
                r_bid    <= w_head_id;
                r_bresp  <= TRANS_WR_RESP_W'(2'b11);
            end else if (w_pop_slv) begin
                r_bvalid <= 1'b1;
                r_bid    <= w_head_rsp[TRANS_WR_RESP_W +: TRANS_MST_ID_W];
                r_bresp  <= w_head_rsp[TRANS_WR_RESP_W-1:0];
            end else if (r_bvalid && m_BREADY_i) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Readies deassert combinationally while reset is held
    assign dsp_AW_ready_o    = !w_ord_full && !ARESET_i;
    assign sa_BREADY_o       = ~w_rsp_full & {SLV_AMT{!ARESET_i}};
    assign m_BVALID_o        = r_bvalid;
    assign m_BID_o           = r_bid;
    assign m_BRESP_o         = r_bresp;
    assign outstanding_cnt_o = r_cnt;

endmodule

// File: tb/tb_dsp_wresp_ordered_router.sv
// Bench for dsp_wresp_ordered_router: queue-based cycle model checked every
// cycle, plus directed scenarios with hand-computed response sequences.
module tb_dsp_wresp_ordered_router;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        aw_en = 1'b0;
    logic [1:0]  aw_slv = '0;
    logic        aw_dec = 1'b0;
    logic [4:0]  aw_id = '0;
    logic        aw_ready;
    logic [19:0] sa_bid = '0;
    logic [7:0]  sa_bresp = '0;
    logic [3:0]  sa_bvalid = '0;
    logic [3:0]  sa_bready;
    logic [4:0]  m_bid;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready = 1'b1;
    logic [3:0]  cnt;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    dsp_wresp_ordered_router dut (
        .ACLK_i            (clk),
        .ARESET_i          (rst),
        .dsp_AW_shift_en_i (aw_en),
        .dsp_AW_slv_id_i   (aw_slv),
        .dsp_AW_decerr_i   (aw_dec),
        .dsp_AW_mst_id_i   (aw_id),
        .dsp_AW_ready_o    (aw_ready),
        .sa_BID_i          (sa_bid),
        .sa_BRESP_i        (sa_bresp),
        .sa_BVALID_i       (sa_bvalid),
        .sa_BREADY_o       (sa_bready),
        .m_BID_o           (m_bid),
        .m_BRESP_o         (m_bresp),
        .m_BVALID_o        (m_bvalid),
        .m_BREADY_i        (m_bready),
        .outstanding_cnt_o (cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pending AWs, per-slave response queues, master output slot
    typedef struct packed {
        logic       dec;
        logic [1:0] slv;
        logic [4:0] id;
    } ord_t;

    ord_t       oq[$];
    int         sq_n[4];
    logic [6:0] sq_d[4][8];
    logic       mv = 1'b0;
    logic [4:0] mid = '0;
    logic [1:0] mresp = '0;
    logic [6:0] got[$];
    logic [6:0] exp_q[$];

    ord_t       m_h;
    bit         m_hs, m_ld, m_pd, m_ps, m_po;
    bit  [3:0]  m_push;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            oq.delete();
            for (int s = 0; s < 4; s++) sq_n[s] = 0;
            mv = 1'b0;
            mid = '0;
            mresp = '0;
        end else begin
            m_hs = mv && m_bready;
            if (m_hs) got.push_back({mid, mresp});
            m_ld = !mv || m_bready;
            m_pd = 1'b0;
            m_ps = 1'b0;
            m_h  = '0;
            if (oq.size() > 0 && m_ld) begin
                m_h = oq[0];
                if (m_h.dec) m_pd = 1'b1;
                else if (sq_n[m_h.slv] > 0) m_ps = 1'b1;
            end
            m_po = aw_en && (oq.size() < 8);
            for (int s = 0; s < 4; s++) m_push[s] = sa_bvalid[s] && (sq_n[s] < 4);

            if (m_pd) begin
                mv = 1'b1;
                mid = m_h.id;
                mresp = 2'b11;
                void'(oq.pop_front());
            end else if (m_ps) begin
                mv = 1'b1;
                {mid, mresp} = sq_d[m_h.slv][0];
                for (int i = 0; i < 7; i++) sq_d[m_h.slv][i] = sq_d[m_h.slv][i+1];
                sq_n[m_h.slv]--;
                void'(oq.pop_front());
            end else if (m_hs) begin
                mv = 1'b0;
            end

            if (m_po) oq.push_back(ord_t'({aw_dec, aw_slv, aw_id}));
            for (int s = 0; s < 4; s++) begin
                if (m_push[s]) begin
                    sq_d[s][sq_n[s]] = {sa_bid[s*5 +: 5], sa_bresp[s*2 +: 2]};
                    sq_n[s]++;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_bvalid", int'(m_bvalid), int'(mv));
            if (mv) begin
                check("m_bid", int'(m_bid), int'(mid));
                check("m_bresp", int'(m_bresp), int'(mresp));
            end
            check("outstanding_cnt", int'(cnt), oq.size());
            check("aw_ready", int'(aw_ready), int'(!rst && oq.size() < 8));
            for (int s = 0; s < 4; s++)
                check("sa_bready", int'(sa_bready[s]), int'(!rst && sq_n[s] < 4));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic aw(input bit dec, input int slv, input int id);
        aw_en  = 1'b1;
        aw_dec = dec;
        aw_slv = 2'(slv);
        aw_id  = 5'(id);
        tick();
        aw_en  = 1'b0;
    endtask

    task automatic slave_send(input int s, input int id, input int resp);
        int n;
        n = 0;
        sa_bid[s*5 +: 5]   = 5'(id);
        sa_bresp[s*2 +: 2] = 2'(resp);
        sa_bvalid[s]       = 1'b1;
        while (!sa_bready[s] && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL slave_send_timeout slave=%0d id=%0d bready stayed 0, required 1", s, id);
        end else begin
            tick();
        end
        sa_bvalid[s] = 1'b0;
    endtask

    task automatic cmp_got(input string name);
        check({name, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            check(name, int'(got[i]), int'(exp_q[i]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired, simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        bit r;
        #1 rst = 1'b1;
        chk_en = 1'b1;
        tick();
        check("rst_bvalid", int'(m_bvalid), 0);
        check("rst_cnt", int'(cnt), 0);
        check("rst_aw_ready", int'(aw_ready), 0);
        check("rst_sa_bready", int'(sa_bready), 0);
        tick();
        rst = 1'b0;
        tick();

        // 1: single transaction latency
        got.delete();
        aw(1'b0, 1, 5);
        check("t1_cnt_after_aw", int'(cnt), 1);
        tick();
        tick();
        slave_send(1, 5, 0);
        check("t1_bvalid_t1", int'(m_bvalid), 0);
        tick();
        check("t1_bvalid_t2", int'(m_bvalid), 1);
        check("t1_bid", int'(m_bid), 5);
        check("t1_bresp", int'(m_bresp), 0);
        check("t1_cnt_done", int'(cnt), 0);
        tick();
        exp_q = '{7'({5'd5, 2'b00})};
        cmp_got("t1_seq");

        // 2: later slave answers first
        got.delete();
        aw(1'b0, 0, 1);
        aw(1'b0, 2, 2);
        slave_send(2, 2, 0);
        repeat (4) begin
            check("t2_bready2_open", int'(sa_bready[2]), 1);
            check("t2_no_early_out", int'(m_bvalid), 0);
            tick();
        end
        slave_send(0, 1, 1);
        repeat (5) tick();
        exp_q = '{7'({5'd1, 2'b01}), 7'({5'd2, 2'b00})};
        cmp_got("t2_seq");

        // 3: DECERR between two slave0 AWs
        got.delete();
        aw(1'b0, 0, 3);
        aw(1'b1, 2, 7);
        aw(1'b0, 0, 4);
        slave_send(0, 3, 2);
        slave_send(0, 4, 0);
        repeat (6) tick();
        exp_q = '{7'({5'd3, 2'b10}), 7'({5'd7, 2'b11}), 7'({5'd4, 2'b00})};
        cmp_got("t3_seq");

        // 4: order FIFO full
        got.delete();
        for (int i = 0; i < 9; i++) aw(1'b0, 3, 10 + i);
        check("t4_full_ready", int'(aw_ready), 0);
        check("t4_full_cnt", int'(cnt), 8);
        slave_send(3, 10, 0);
        check("t4_ready_before_pop", int'(aw_ready), 0);
        tick();
        check("t4_ready_after_pop", int'(aw_ready), 1);
        check("t4_cnt_after_pop", int'(cnt), 7);
        for (int i = 11; i < 18; i++) slave_send(3, i, 0);
        repeat (6) tick();
        check("t4_cnt_drained", int'(cnt), 0);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back({5'(10 + i), 2'b00});
        cmp_got("t4_seq");

        // 5: master backpressure while slave1 streams
        got.delete();
        for (int i = 0; i < 6; i++) aw(1'b0, 1, 20 + i);
        m_bready = 1'b0;
        idx = 0;
        for (int c = 0; c < 25; c++) begin
            if (c == 10) begin
                check("t5_bready1_low", int'(sa_bready[1]), 0);
                check("t5_bvalid_held", int'(m_bvalid), 1);
                check("t5_bid_held", int'(m_bid), 20);
                check("t5_accepted", idx, 5);
                m_bready = 1'b1;
            end
            if (idx < 6) begin
                sa_bvalid[1]  = 1'b1;
                sa_bid[5 +: 5] = 5'(20 + idx);
                sa_bresp[2 +: 2] = 2'b00;
            end else begin
                sa_bvalid[1] = 1'b0;
            end
            r = sa_bready[1] && sa_bvalid[1];
            tick();
            if (r) idx++;
        end
        sa_bvalid[1] = 1'b0;
        repeat (4) tick();
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back({5'(20 + i), 2'b00});
        cmp_got("t5_seq");

        // 6: reset with pending work
        got.delete();
        m_bready = 1'b0;
        aw(1'b0, 0, 1);
        aw(1'b0, 0, 2);
        aw(1'b0, 0, 3);
        slave_send(0, 1, 0);
        tick();
        check("t6_pre_valid", int'(m_bvalid), 1);
        check("t6_pre_cnt", int'(cnt), 2);
        rst = 1'b1;
        #1;
        check("t6_rst_bvalid", int'(m_bvalid), 0);
        check("t6_rst_cnt", int'(cnt), 0);
        check("t6_rst_aw_ready", int'(aw_ready), 0);
        check("t6_rst_sa_bready", int'(sa_bready), 0);
        tick();
        tick();
        rst = 1'b0;
        m_bready = 1'b1;
        got.delete();
        tick();
        aw(1'b0, 2, 9);
        slave_send(2, 9, 1);
        repeat (4) tick();
        check("t6_cnt_after", int'(cnt), 0);
        exp_q = '{7'({5'd9, 2'b01})};
        cmp_got("t6_seq");

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
